// File: rtl/usb_bus_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : usb_bus_master_if
//  Description : Bundles the signals between the burst master and the rest of
//                the system. The bundle covers the command channel, the write
//                and read byte streams, and the external 8-bit strobed bus.
//  Ports       : master modport -> used by usb_bus_master
//                slave  modport -> used by the command source and bus model
//  Revision    : 1.0 - initial release
// ============================================================================
interface usb_bus_master_if #(
    parameter int ABUSWIDTH = 16
);
    // Command channel
    logic                 CMD_VALID;
    logic                 CMD_READY;
    logic                 CMD_WRITE;
    logic [ABUSWIDTH-1:0] CMD_ADD;
    logic [7:0]           CMD_LEN;
    logic                 CMD_INC;
    // Write byte stream
    logic [7:0]           WR_DATA;
    logic                 WR_DATA_VALID;
    logic                 WR_DATA_READY;
    // Read byte stream
    logic [7:0]           RD_DATA;
    logic                 RD_DATA_VALID;
    logic                 RD_DATA_READY;
    // External bus
    logic [ABUSWIDTH-1:0] ADD;
    logic [7:0]           DATA_OUT;
    logic                 DATA_OE;
    logic [7:0]           DATA_IN;
    logic                 RD_B;
    logic                 WR_B;
    // Status
    logic                 BUSY;
    logic                 DONE;

    modport master (
        input  CMD_VALID, CMD_WRITE, CMD_ADD, CMD_LEN, CMD_INC,
        input  WR_DATA, WR_DATA_VALID, RD_DATA_READY, DATA_IN,
        output CMD_READY, WR_DATA_READY, RD_DATA, RD_DATA_VALID,
        output ADD, DATA_OUT, DATA_OE, RD_B, WR_B, BUSY, DONE
    );

    modport slave (
        output CMD_VALID, CMD_WRITE, CMD_ADD, CMD_LEN, CMD_INC,
        output WR_DATA, WR_DATA_VALID, RD_DATA_READY, DATA_IN,
        input  CMD_READY, WR_DATA_READY, RD_DATA, RD_DATA_VALID,
        input  ADD, DATA_OUT, DATA_OE, RD_B, WR_B, BUSY, DONE
    );
endinterface
`default_nettype wire

// File: rtl/usb_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : usb_bus_master
//  Description : Burst master for an 8-bit asynchronous strobed bus. It
//                accepts a read or write command of 1..256 bytes. Each byte
//                runs through SETUP, STROBE and HOLD phases of configurable
//                length, and the address either increments or stays fixed.
//  Ports       : BUS_CLK  - sole clock (rising edge)
//                BUS_RST  - synchronous active-high reset
//                bus      - usb_bus_master_if.master (command, byte streams,
//                           external bus, BUSY/DONE status)
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_bus_master #(
    parameter int ABUSWIDTH     = 16,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  wire logic        BUS_CLK,
    input  wire logic        BUS_RST,
    usb_bus_master_if.master bus
);
    // The phase counter only needs to reach the longest of the three phases.
    localparam int c_max_ss = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int c_max_ph = (c_max_ss > HOLD_CYCLES) ? c_max_ss : HOLD_CYCLES;
    localparam int c_pw     = (c_max_ph > 1) ? $clog2(c_max_ph) : 1;

    localparam logic [c_pw-1:0] c_setup_last  = c_pw'(SETUP_CYCLES - 1);
    localparam logic [c_pw-1:0] c_strobe_last = c_pw'(STROBE_CYCLES - 1);
    localparam logic [c_pw-1:0] c_hold_last   = c_pw'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_WDATA = 3'd1,
        S_SETUP      = 3'd2,
        S_STROBE     = 3'd3,
        S_HOLD       = 3'd4,
        S_WAIT_RDOUT = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic                 r_write;
    logic                 r_inc;
    logic [8:0]           r_cnt;        // bytes remaining, 1..256 while busy
    logic [c_pw-1:0]      r_phase;
    logic [ABUSWIDTH-1:0] r_byte_add;   // address of the byte in progress
    logic [ABUSWIDTH-1:0] r_add;        // address driven on the bus
    logic [7:0]           r_data_out;
    logic                 r_oe;
    logic [7:0]           r_rd_data;
    logic                 r_done;

    logic                 w_cmd_ready;
    logic                 w_wr_ready;
    logic                 w_rd_valid;
    logic                 w_rd_b;
    logic                 w_wr_b;
    logic                 w_phase_last;
    logic                 w_byte_end;
    logic                 w_last_byte;
    logic                 w_accept;
    logic                 w_enter_setup;
    logic                 w_enter_idle;
    logic                 w_write_eff;
    logic [ABUSWIDTH-1:0] w_next_byte_add;
    logic [ABUSWIDTH-1:0] w_setup_add;

    assign w_last_byte     = (r_cnt == 9'd1);
    assign w_accept        = bus.CMD_VALID && w_cmd_ready;
    assign w_next_byte_add = r_inc ? (r_byte_add + ABUSWIDTH'(1)) : r_byte_add;
    assign w_enter_setup   = (w_next == S_SETUP) && (r_state != S_SETUP);
    assign w_enter_idle    = (w_next == S_IDLE) && (r_state != S_IDLE);
    // The command fields are only valid during the accept cycle itself.
    assign w_write_eff     = (r_state == S_IDLE) ? bus.CMD_WRITE : r_write;

    // Bus address for the byte about to be set up. A read loops straight from
    // WAIT_RDOUT into SETUP, so it must use the already-advanced address.
    always_comb begin
        w_setup_add = r_byte_add;
        if (r_state == S_IDLE) begin
            w_setup_add = bus.CMD_ADD;
        end else if (r_state == S_WAIT_RDOUT) begin
            w_setup_add = w_next_byte_add;
        end
    end

    // State register
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_next       = r_state;
        w_cmd_ready  = 1'b0;
        w_wr_ready   = 1'b0;
        w_rd_valid   = 1'b0;
        w_rd_b       = 1'b1;
        w_wr_b       = 1'b1;
        w_phase_last = 1'b0;
        w_byte_end   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = !BUS_RST;
                if (bus.CMD_VALID && !BUS_RST) begin
                    w_next = bus.CMD_WRITE ? S_WAIT_WDATA : S_SETUP;
                end
            end
            S_WAIT_WDATA: begin
                w_wr_ready = 1'b1;
                if (bus.WR_DATA_VALID) begin
                    w_next = S_SETUP;
                end
            end
            S_SETUP: begin
                w_phase_last = (r_phase == c_setup_last);
                if (w_phase_last) begin
                    w_next = S_STROBE;
                end
            end
            S_STROBE: begin
                w_wr_b       = !r_write;
                w_rd_b       = r_write;
                w_phase_last = (r_phase == c_strobe_last);
                if (w_phase_last) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                w_phase_last = (r_phase == c_hold_last);
                if (w_phase_last) begin
                    if (r_write) begin
                        w_byte_end = 1'b1;
                        w_next     = w_last_byte ? S_IDLE : S_WAIT_WDATA;
                    end else begin
                        w_next = S_WAIT_RDOUT;
                    end
                end
            end
            S_WAIT_RDOUT: begin
                w_rd_valid = 1'b1;
                if (bus.RD_DATA_READY) begin
                    w_byte_end = 1'b1;
                    w_next     = w_last_byte ? S_IDLE : S_SETUP;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            r_write    <= 1'b0;
            r_inc      <= 1'b0;
            r_cnt      <= 9'd0;
            r_phase    <= '0;
            r_byte_add <= '0;
            r_add      <= '0;
            r_data_out <= 8'd0;
            r_oe       <= 1'b0;
            r_rd_data  <= 8'd0;
            r_done     <= 1'b0;
        end else begin
            // A reset never reaches this branch, so an aborted burst never
            // produces DONE.
            r_done <= w_enter_idle;

            if (w_next != r_state) begin
                r_phase <= '0;
            end else if (r_state == S_SETUP || r_state == S_STROBE || r_state == S_HOLD) begin
                r_phase <= r_phase + c_pw'(1);
            end

            if (r_state == S_IDLE && w_accept) begin
                r_write    <= bus.CMD_WRITE;
                r_inc      <= bus.CMD_INC;
                r_byte_add <= bus.CMD_ADD;
                r_cnt      <= (bus.CMD_LEN == 8'd0) ? 9'd256 : {1'b0, bus.CMD_LEN};
            end

            if (r_state == S_WAIT_WDATA && bus.WR_DATA_VALID) begin
                r_data_out <= bus.WR_DATA;
            end

            if (r_state == S_STROBE && w_phase_last && !r_write) begin
                r_rd_data <= bus.DATA_IN;
            end

            if (w_byte_end) begin
                r_cnt      <= r_cnt - 9'd1;
                r_byte_add <= w_next_byte_add;
            end

            // Bus-facing address and output enable only move at phase
            // boundaries, which keeps them stable across the strobe and hold.
            if (w_enter_setup) begin
                r_add <= w_setup_add;
                r_oe  <= w_write_eff;
            end
            if (w_enter_idle) begin
                r_oe <= 1'b0;
            end
        end
    end

    assign bus.CMD_READY     = w_cmd_ready;
    assign bus.WR_DATA_READY = w_wr_ready;
    assign bus.RD_DATA       = r_rd_data;
    assign bus.RD_DATA_VALID = w_rd_valid;
    assign bus.ADD           = r_add;
    assign bus.DATA_OUT      = r_data_out;
    assign bus.DATA_OE       = r_oe;
    assign bus.RD_B          = w_rd_b;
    assign bus.WR_B          = w_wr_b;
    assign bus.BUSY          = (r_state != S_IDLE);
    assign bus.DONE          = r_done;
endmodule
`default_nettype wire

// File: doc/usb_bus_master.md
USB_BUS_MASTER -- requirements
Module: usb_bus_master

Interface
REQ-001 Parameter ABUSWIDTH, default 16, bus address width.
REQ-002 Parameter SETUP_CYCLES, default 1 (min 1), cycles ADD/DATA are stable with both strobes high before the strobe.
REQ-003 Parameter STROBE_CYCLES, default 2 (min 1), cycles RD_B or WR_B is held low.
REQ-004 Parameter HOLD_CYCLES, default 1 (min 1), cycles ADD/DATA are stable after the strobe deasserts.
REQ-005 BUS_CLK  in  1  sole clock; every flop is rising-edge BUS_CLK.
REQ-006 BUS_RST  in  1  synchronous, active-high reset.
REQ-007 CMD_VALID  in  1  command offered.
REQ-008 CMD_READY  out  1  high only in IDLE; a command is accepted on a cycle with CMD_VALID & CMD_READY.
REQ-009 CMD_WRITE  in  1  1 = write burst, 0 = read burst.
REQ-010 CMD_ADD  in  ABUSWIDTH  start address.
REQ-011 CMD_LEN  in  8  byte count; 0 means 256.
REQ-012 CMD_INC  in  1  1 = increment address per byte, 0 = fixed address (FIFO port).
REQ-013 WR_DATA  in  8 / WR_DATA_VALID  in  1 / WR_DATA_READY  out  1  write byte stream.
REQ-014 RD_DATA  out  8 / RD_DATA_VALID  out  1 / RD_DATA_READY  in  1  read byte stream.
REQ-015 ADD  out  ABUSWIDTH  bus address.
REQ-016 DATA_OUT  out  8 / DATA_OE  out  1  write data and output enable for the external tristate.
REQ-017 DATA_IN  in  8  read data from the bus.
REQ-018 RD_B  out  1 / WR_B  out  1  active-low strobes.
REQ-019 BUSY  out  1 (high whenever state != IDLE) / DONE  out  1 (one-cycle pulse at burst end).

Function
REQ-020 States SHALL be: IDLE, WAIT_WDATA, SETUP, STROBE, HOLD, WAIT_RDOUT.
REQ-021 IDLE: on accept, the block SHALL latch ADD, CMD_WRITE, CMD_INC and remaining count (0 -> 256), then go to WAIT_WDATA if writing, else to SETUP.
REQ-022 WAIT_WDATA: WR_DATA_READY SHALL be 1; on WR_DATA_VALID the block SHALL latch DATA_OUT and go to SETUP; WR_DATA_READY SHALL be 0 in all other states.
REQ-023 SETUP: RD_B = WR_B = 1 and DATA_OE = CMD_WRITE for exactly SETUP_CYCLES cycles, then STROBE.
REQ-024 STROBE: WR_B = 0 (write) or RD_B = 0 (read) for exactly STROBE_CYCLES cycles; the two strobes SHALL never be low together.
REQ-025 Read data: DATA_IN SHALL be captured on the clock edge that ends the last STROBE cycle.
REQ-026 HOLD: both strobes high, ADD and DATA_OUT unchanged, DATA_OE held, for exactly HOLD_CYCLES cycles.
REQ-027 After HOLD on a read, the block SHALL present the captured byte with RD_DATA_VALID = 1 in WAIT_RDOUT until the cycle with RD_DATA_READY = 1; RD_DATA SHALL be stable while valid.
REQ-028 Byte end (after the HOLD of a write, or the RD_DATA handshake of a read): count decrements.
REQ-029 Byte end, count reaches 0: DATA_OE SHALL drop, DONE SHALL pulse for 1 cycle, and the FSM SHALL go to IDLE.
REQ-030 Byte end, count not 0: ADD increments if CMD_INC, and the FSM returns to WAIT_WDATA (write) or SETUP (read).
REQ-031 ADD increment SHALL wrap modulo 2^ABUSWIDTH (0xFFFF -> 0x0000).
REQ-032 ADD, DATA_OUT and DATA_OE SHALL change only in the cycle entering SETUP or IDLE, never while a strobe is low.
REQ-033 Commands offered while BUSY SHALL be ignored and not queued.
REQ-034 WR_DATA_VALID in non-WAIT_WDATA states SHALL be ignored.

Reset
REQ-035 On BUS_RST (including mid-burst) the next state SHALL be IDLE with these output values: RD_B = WR_B = 1, DATA_OE = 0, ADD = 0, DATA_OUT = 0, RD_DATA = 0, RD_DATA_VALID = 0, WR_DATA_READY = 0, BUSY = 0, DONE = 0. Remaining count is cleared, and any partial burst is discarded without a DONE pulse.
REQ-036 CMD_READY SHALL be 0 while BUS_RST is high and 1 from the first cycle after it drops.

Verification
REQ-037 Single write, default parameters: write to ADD 0x4000, LEN 1, data 0xA5 present at accept -> DATA_OE high for 4 cycles, WR_B low for exactly cycles 3-4 after accept, and DONE in the cycle after HOLD.
REQ-038 Read burst: ADD 0x8100, LEN 4, CMD_INC = 1, bus model returning the low address byte, RD_DATA_READY = 1 -> RD_DATA sequence 0x00, 0x01, 0x02, 0x03, RD_B low 4 times with 2 cycles each, then one DONE.
REQ-039 Backpressure: read LEN 2 with RD_DATA_READY held low for 10 cycles -> RD_DATA_VALID stays high and stable, and no second RD_B pulse until the handshake.
REQ-040 Wrap and length 0: write at ADD 0xFFFF, LEN 0, INC = 1 -> exactly 256 WR_B pulses, second address 0x0000, last address 0x00FE.
REQ-041 Reset mid-burst: BUS_RST asserted while WR_B is low -> the next cycle shows WR_B = 1, DATA_OE = 0, and BUSY = 0, with no DONE pulse, and a new command is accepted normally afterwards.
REQ-042 Fixed address and write starvation: INC = 0, LEN 3, WR_DATA_VALID gapped -> ADD is constant, a strobe occurs only after each write-data handshake, and there is never an RD_B pulse.
